// File: rtl/mic_i2s_capture.sv
// I2S microphone capture: bit-clock/word-select generation, MSB-first
// deserialisation, channel filtering and a buffered read port with level/overflow.
module mic_i2s_capture #(
  parameter int DAT_WIDTH = 18,
  parameter int SLOT_BITS = 32,
  parameter int CLK_DIV   = 32,
  parameter int ADR_WIDTH = 9,
  parameter int CH_MODE   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 mclk,
  output logic                 ws,
  output logic                 lr,
  input  logic                 dataint,
  input  logic                 rd,
  output logic [DAT_WIDTH-1:0] data_out,
  output logic                 ch_out,
  output logic                 data_valid,
  output logic                 empty,
  output logic                 full,
  output logic [ADR_WIDTH:0]   level,
  output logic                 overflow,
  input  logic                 clr_ovf
);

  localparam int HALF_DIV   = CLK_DIV / 2;
  localparam int DIV_W      = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DEPTH      = 1 << ADR_WIDTH;
  localparam int LVL_W      = ADR_WIDTH + 1;
  localparam int WORD_W     = DAT_WIDTH + 1;

  // ---------------------------------------------------------------- clocking
  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_cnt_next;
  logic             mclk_reg;
  logic             ws_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [BIT_W-1:0] bit_cnt_next;
  logic [BIT_W-1:0] slot_idx;
  logic             term_cnt;
  logic             rise_evt;
  logic             fall_evt;

  always_comb begin
    term_cnt     = enable && (div_cnt_reg == DIV_W'(HALF_DIV - 1));
    rise_evt     = term_cnt && !mclk_reg;
    fall_evt     = term_cnt && mclk_reg;
    div_cnt_next = term_cnt ? '0 : div_cnt_reg + DIV_W'(1);
    bit_cnt_next = (bit_cnt_reg == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt_reg + BIT_W'(1);
    slot_idx     = (bit_cnt_reg >= BIT_W'(SLOT_BITS)) ? bit_cnt_reg - BIT_W'(SLOT_BITS)
                                                      : bit_cnt_reg;
  end

  // Disabling returns the interface to the start of a left slot.
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      div_cnt_reg <= '0;
      mclk_reg    <= 1'b0;
      bit_cnt_reg <= '0;
      ws_reg      <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      if (term_cnt) begin
        mclk_reg <= ~mclk_reg;
      end
      if (fall_evt) begin
        bit_cnt_reg <= bit_cnt_next;
        ws_reg      <= (bit_cnt_next >= BIT_W'(SLOT_BITS));
      end
    end
  end

  // ----------------------------------------------------------------- capture
  logic                 capture_bit;
  logic                 word_done;
  logic                 ch_allowed;
  logic [DAT_WIDTH-1:0] shift_next;
  logic [WORD_W-1:0]    wr_word;

  always_comb begin
    capture_bit = rise_evt && (slot_idx >= BIT_W'(1)) && (slot_idx <= BIT_W'(DAT_WIDTH));
    word_done   = rise_evt && (slot_idx == BIT_W'(DAT_WIDTH));
    wr_word     = {ws_reg, shift_next};
  end

  generate
    if (CH_MODE == 0) begin : g_left
      assign ch_allowed = !ws_reg;
    end else if (CH_MODE == 1) begin : g_right
      assign ch_allowed = ws_reg;
    end else begin : g_stereo
      assign ch_allowed = 1'b1;
    end
  endgenerate

  // The word being pushed includes the bit sampled on this very edge, so only
  // DAT_WIDTH-1 bits ever need to be stored.
  assign shift_next[0] = dataint;

  genvar gi;
  generate
    if (DAT_WIDTH > 1) begin : g_shift
      logic [DAT_WIDTH-2:0] shift_reg;

      always_ff @(posedge clk) begin
        if (!reset || !enable) begin
          shift_reg <= '0;
        end else if (capture_bit) begin
          shift_reg <= shift_next[DAT_WIDTH-2:0];
        end
      end

      for (gi = 1; gi < DAT_WIDTH; gi++) begin : g_bit
        assign shift_next[gi] = shift_reg[gi-1];
      end
    end
  endgenerate

  // -------------------------------------------------------------------- fifo
  logic [WORD_W-1:0]    mem_reg [DEPTH];
  logic [ADR_WIDTH-1:0] wr_ptr_reg;
  logic [ADR_WIDTH-1:0] rd_ptr_reg;
  logic [LVL_W-1:0]     level_reg;
  logic [LVL_W-1:0]     level_next;
  logic                 empty_w;
  logic                 full_w;
  logic                 push;
  logic                 do_read;
  logic                 do_write;
  logic                 drop;

  // A push into a full fifo still lands when the same cycle frees the head slot.
  always_comb begin
    empty_w  = (level_reg == '0);
    full_w   = (level_reg == LVL_W'(DEPTH));
    push     = word_done && ch_allowed;
    do_read  = rd && !empty_w;
    do_write = push && (!full_w || do_read);
    drop     = push && full_w && !do_read;
    level_next = level_reg;
    case ({do_write, do_read})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && do_write) begin
      mem_reg[wr_ptr_reg] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      level_reg <= level_next;
      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + ADR_WIDTH'(1);
      end
      if (do_read) begin
        rd_ptr_reg <= rd_ptr_reg + ADR_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------- read and flags
  logic [DAT_WIDTH-1:0] data_out_reg;
  logic                 ch_out_reg;
  logic                 data_valid_reg;
  logic                 overflow_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out_reg   <= '0;
      ch_out_reg     <= 1'b0;
      data_valid_reg <= 1'b0;
    end else begin
      data_valid_reg <= do_read;
      if (do_read) begin
        {ch_out_reg, data_out_reg} <= mem_reg[rd_ptr_reg];
      end
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (clr_ovf) begin
      overflow_reg <= 1'b0;
    end
  end

  assign mclk       = mclk_reg;
  assign ws         = ws_reg;
  assign lr         = (CH_MODE == 1) ? 1'b1 : 1'b0;
  assign data_out   = data_out_reg;
  assign ch_out     = ch_out_reg;
  assign data_valid = data_valid_reg;
  assign empty      = empty_w;
  assign full       = full_w;
  assign level      = level_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_mic_i2s_capture.sv
// Bench for mic_i2s_capture: a stereo and a right-only instance share the serial
// input; a queue-based model built from edge counts predicts every output.
module tb_mic_i2s_capture;

  localparam int DW    = 6;
  localparam int SB    = 8;
  localparam int CD    = 4;
  localparam int AW    = 2;
  localparam int HALF  = CD / 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0, enable = 1'b0, dataint = 1'b0;
  logic rd_a = 1'b0, rd_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;

  logic          mclk_a, ws_a, lr_a, ch_a, dv_a, empty_a, full_a, ovf_a;
  logic [DW-1:0] dout_a;
  logic [AW:0]   level_a;
  logic          mclk_b, ws_b, lr_b, ch_b, dv_b, empty_b, full_b, ovf_b;
  logic [DW-1:0] dout_b;
  logic [AW:0]   level_b;

  mic_i2s_capture #(.DAT_WIDTH(DW), .SLOT_BITS(SB), .CLK_DIV(CD), .ADR_WIDTH(AW), .CH_MODE(2)) u_dut_st (
    .clk(clk), .reset(reset), .enable(enable), .mclk(mclk_a), .ws(ws_a), .lr(lr_a),
    .dataint(dataint), .rd(rd_a), .data_out(dout_a), .ch_out(ch_a), .data_valid(dv_a),
    .empty(empty_a), .full(full_a), .level(level_a), .overflow(ovf_a), .clr_ovf(clr_a));

  mic_i2s_capture #(.DAT_WIDTH(DW), .SLOT_BITS(SB), .CLK_DIV(CD), .ADR_WIDTH(AW), .CH_MODE(1)) u_dut_r (
    .clk(clk), .reset(reset), .enable(enable), .mclk(mclk_b), .ws(ws_b), .lr(lr_b),
    .dataint(dataint), .rd(rd_b), .data_out(dout_b), .ch_out(ch_b), .data_valid(dv_b),
    .empty(empty_b), .full(full_b), .level(level_b), .overflow(ovf_b), .clr_ovf(clr_b));

  // Reference model state
  int            en_edges = 0;
  int            last_nb = -1;
  logic [DW-1:0] cur_word = '0;
  logic          cur_ch = 1'b0;
  logic [DW-1:0] tx_q[$];
  logic [DW:0]   sent[$];
  logic [DW:0]   qa[$], qb[$];
  logic [DW:0]   m_out_a = '0, m_out_b = '0;
  logic          m_dv_a = 1'b0, m_dv_b = 1'b0, m_ovf_a = 1'b0, m_ovf_b = 1'b0;

  int checks = 0;
  int errors = 0;

  // Bit index within the frame for the mclk rise on enabled edge e, or -1.
  function automatic int rise_bit(input int e);
    if (e <= 0 || (e % HALF) != 0) return -1;
    if (((e / HALF) % 2) == 0) return -1;
    return (((e / HALF) + 1) / 2 - 1) % (2 * SB);
  endfunction

  function automatic logic next_push();
    int nb;
    nb = (enable && reset) ? rise_bit(en_edges + 1) : -1;
    return (nb >= 0) && ((nb % SB) == DW);
  endfunction

  // Drive dataint for the coming edge, take the edge, update the model, return at negedge.
  task automatic cycle();
    int nb, idx;
    logic [DW:0] w;
    logic rok, full_q, drop, push_a, push_b;
    nb = (enable && reset) ? rise_bit(en_edges + 1) : -1;
    dataint = 1'($urandom_range(0, 1));
    w = '0;
    if (nb >= 0) begin
      idx = nb % SB;
      if (idx == 1) begin
        cur_ch = (nb >= SB);
        if (tx_q.size() > 0) cur_word = tx_q.pop_front();
        else cur_word = DW'($urandom);
      end
      if (idx >= 1 && idx <= DW) dataint = cur_word[DW-idx];
    end
    @(posedge clk);
    last_nb = nb;
    if (!reset) begin
      en_edges = 0;
      qa.delete(); qb.delete();
      m_out_a = '0; m_out_b = '0; m_dv_a = 1'b0; m_dv_b = 1'b0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    end else begin
      en_edges = enable ? en_edges + 1 : 0;
      push_a = 1'b0; push_b = 1'b0;
      if (nb >= 0 && (nb % SB) == DW) begin
        w = {cur_ch, cur_word};
        sent.push_back(w);
        push_a = 1'b1;
        push_b = cur_ch;
      end
      rok = rd_a && (qa.size() > 0); full_q = (qa.size() == DEPTH);
      m_dv_a = rok;
      if (rok) m_out_a = qa.pop_front();
      drop = push_a && full_q && !rok;
      if (push_a && !drop) qa.push_back(w);
      if (drop) m_ovf_a = 1'b1; else if (clr_a) m_ovf_a = 1'b0;
      rok = rd_b && (qb.size() > 0); full_q = (qb.size() == DEPTH);
      m_dv_b = rok;
      if (rok) m_out_b = qb.pop_front();
      drop = push_b && full_q && !rok;
      if (push_b && !drop) qb.push_back(w);
      if (drop) m_ovf_b = 1'b1; else if (clr_b) m_ovf_b = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; rd_a = 1'b0; rd_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    tx_q.delete(); sent.delete();
    repeat (3) cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mclk_a !== 1'b0) begin errors++; $display("FAIL reset_mclk: got %b expected 0", mclk_a); end
    checks++; if (ws_a !== 1'b0) begin errors++; $display("FAIL reset_ws: got %b expected 0", ws_a); end
    checks++; if (dout_a !== '0 || ch_a !== 1'b0) begin errors++; $display("FAIL reset_dout: got %h/%b expected 0/0", dout_a, ch_a); end
    checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", dv_a); end
    checks++; if (empty_a !== 1'b1 || full_a !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b expected 1/0", empty_a, full_a); end
    checks++; if (level_a !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_a); end
    checks++; if (lr_a !== 1'b0) begin errors++; $display("FAIL lr_stereo: got %b expected 0", lr_a); end
    checks++; if (lr_b !== 1'b1) begin errors++; $display("FAIL lr_right: got %b expected 1", lr_b); end
    checks++; if (empty_b !== 1'b1 || level_b !== '0) begin errors++; $display("FAIL reset_b: got empty=%b level=%0d expected 1/0", empty_b, level_b); end
  endtask

  task automatic test_clocking();
    int first_rise, last_toggle;
    logic prev_ws, exp_m, exp_w;
    first_rise = -1; last_toggle = 0; prev_ws = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 160; i++) begin
      cycle();
      exp_m = ((en_edges / HALF) % 2) == 1;
      exp_w = ((en_edges / HALF / 2) % (2 * SB)) >= SB;
      checks++; if (mclk_a !== exp_m) begin errors++; $display("FAIL clk_mclk cyc %0d: got %b expected %b", i, mclk_a, exp_m); end
      checks++; if (ws_a !== exp_w) begin errors++; $display("FAIL clk_ws cyc %0d: got %b expected %b", i, ws_a, exp_w); end
      if (mclk_a === 1'b1 && first_rise < 0) first_rise = i;
      if (ws_a !== prev_ws) begin
        checks++; if (i - last_toggle !== SB * CD) begin errors++; $display("FAIL ws_period: got %0d expected %0d", i - last_toggle, SB * CD); end
        last_toggle = i; prev_ws = ws_a;
      end
    end
    checks++; if (first_rise !== HALF) begin errors++; $display("FAIL first_rise: got %0d expected %0d", first_rise, HALF); end
  endtask

  task automatic test_stereo();
    int n;
    do_reset();
    tx_q.push_back(6'b101101); tx_q.push_back(6'b010011);
    enable = 1'b1;
    n = 0;
    while (qa.size() < 2 && n < 300) begin cycle(); n++; end
    checks++; if (n >= 300) begin errors++; $display("FAIL stereo_timeout: got %0d words expected 2", qa.size()); end
    enable = 1'b0;
    cycle();
    checks++; if (level_a !== 3'd2) begin errors++; $display("FAIL stereo_level: got %0d expected 2", level_a); end
    checks++; if (level_b !== 3'd1) begin errors++; $display("FAIL right_level: got %0d expected 1", level_b); end
    rd_a = 1'b1; cycle(); rd_a = 1'b0;
    $display("read st: dv=%b ch=%b data=%h", dv_a, ch_a, dout_a);
    checks++; if (dv_a !== 1'b1 || dout_a !== 6'h2D || ch_a !== 1'b0) begin errors++; $display("FAIL stereo_left: got dv=%b %h/%b expected 1 2d/0", dv_a, dout_a, ch_a); end
    cycle();
    checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL dv_pulse: got %b expected 0", dv_a); end
    rd_a = 1'b1; cycle(); rd_a = 1'b0;
    $display("read st: dv=%b ch=%b data=%h", dv_a, ch_a, dout_a);
    checks++; if (dv_a !== 1'b1 || dout_a !== 6'h13 || ch_a !== 1'b1) begin errors++; $display("FAIL stereo_right: got dv=%b %h/%b expected 1 13/1", dv_a, dout_a, ch_a); end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL stereo_empty: got %b expected 1", empty_a); end
  endtask

  task automatic test_mode_filter();
    int n;
    do_reset();
    enable = 1'b1;
    n = 0;
    while (qb.size() < 4 && n < 400) begin cycle(); n++; end
    checks++; if (n >= 400) begin errors++; $display("FAIL mode_timeout: got %0d words expected 4", qb.size()); end
    enable = 1'b0;
    cycle();
    checks++; if (level_b !== 3'd4 || full_b !== 1'b1) begin errors++; $display("FAIL mode_level: got %0d full=%b expected 4/1", level_b, full_b); end
    checks++; if (lr_b !== 1'b1 || ovf_b !== 1'b0) begin errors++; $display("FAIL mode_lr_ovf: got lr=%b ovf=%b expected 1/0", lr_b, ovf_b); end
    checks++; if (ovf_a !== m_ovf_a) begin errors++; $display("FAIL stereo_ovf: got %b expected %b", ovf_a, m_ovf_a); end
    for (int i = 0; i < 4; i++) begin
      rd_b = 1'b1; cycle(); rd_b = 1'b0;
      $display("read r: dv=%b ch=%b data=%h", dv_b, ch_b, dout_b);
      checks++; if (dv_b !== 1'b1 || ch_b !== 1'b1 || {ch_b, dout_b} !== m_out_b) begin errors++; $display("FAIL mode_word %0d: got dv=%b %b/%h expected 1 %h", i, dv_b, ch_b, dout_b, m_out_b); end
    end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    enable = 1'b1;
    n = 0;
    while (sent.size() < 5 && n < 400) begin cycle(); n++; end
    checks++; if (n >= 400) begin errors++; $display("FAIL ovf_timeout: got %0d words expected 5", sent.size()); end
    enable = 1'b0;
    cycle();
    checks++; if (full_a !== 1'b1 || level_a !== 3'd4) begin errors++; $display("FAIL ovf_full: got full=%b level=%0d expected 1/4", full_a, level_a); end
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf_a); end
    for (int i = 0; i < 4; i++) begin
      rd_a = 1'b1; cycle(); rd_a = 1'b0;
      $display("read st: dv=%b ch=%b data=%h", dv_a, ch_a, dout_a);
      checks++; if (dv_a !== 1'b1 || {ch_a, dout_a} !== sent[i]) begin errors++; $display("FAIL ovf_order %0d: got dv=%b %b/%h expected 1 %h", i, dv_a, ch_a, dout_a, sent[i]); end
    end
    clr_a = 1'b1; cycle(); clr_a = 1'b0;
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf_a); end
  endtask

  task automatic test_full_with_read();
    int n;
    do_reset();
    enable = 1'b1;
    n = 0;
    while (qa.size() < 4 && n < 400) begin cycle(); n++; end
    n = 0;
    while (!next_push() && n < 100) begin cycle(); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL fwr_timeout: got %0d cycles expected a push", n); end
    rd_a = 1'b1; cycle(); rd_a = 1'b0;
    $display("read st: dv=%b ch=%b data=%h", dv_a, ch_a, dout_a);
    checks++; if (level_a !== 3'd4 || full_a !== 1'b1) begin errors++; $display("FAIL fwr_level: got %0d full=%b expected 4/1", level_a, full_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL fwr_ovf: got %b expected 0", ovf_a); end
    checks++; if (dv_a !== 1'b1 || {ch_a, dout_a} !== sent[0]) begin errors++; $display("FAIL fwr_data: got dv=%b %b/%h expected 1 %h", dv_a, ch_a, dout_a, sent[0]); end
  endtask

  task automatic test_empty_disable();
    int n;
    do_reset();
    rd_a = 1'b1; cycle(); rd_a = 1'b0;
    checks++; if (dv_a !== 1'b0 || dout_a !== '0) begin errors++; $display("FAIL empty_read: got dv=%b data=%h expected 0/00", dv_a, dout_a); end
    enable = 1'b1;
    n = 0;
    while (last_nb != 3 && n < 100) begin cycle(); n++; end
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++; if (mclk_a !== 1'b0 || ws_a !== 1'b0) begin errors++; $display("FAIL disabled_clk: got mclk=%b ws=%b expected 0/0", mclk_a, ws_a); end
    end
    checks++; if (level_a !== '0) begin errors++; $display("FAIL no_partial: got level %0d expected 0", level_a); end
    enable = 1'b1;
    n = 0;
    while (!next_push() && n < 200) begin cycle(); n++; end
    rd_a = 1'b1; cycle(); rd_a = 1'b0;
    checks++; if (dv_a !== 1'b0 || level_a !== 3'd1) begin errors++; $display("FAIL push_rd_empty: got dv=%b level=%0d expected 0/1", dv_a, level_a); end
    rd_a = 1'b1; cycle(); rd_a = 1'b0;
    $display("read st: dv=%b ch=%b data=%h", dv_a, ch_a, dout_a);
    checks++; if (dv_a !== 1'b1 || ch_a !== 1'b0 || {ch_a, dout_a} !== sent[0]) begin errors++; $display("FAIL reenable_left: got dv=%b %b/%h expected 1 %h", dv_a, ch_a, dout_a, sent[0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 700; i++) begin
      rd_a  = (i < 350) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 3) == 0);
      rd_b  = ($urandom_range(0, 15) == 0);
      clr_a = ($urandom_range(0, 15) == 0);
      clr_b = ($urandom_range(0, 15) == 0);
      cycle();
      checks++; if (dv_a !== m_dv_a || {ch_a, dout_a} !== m_out_a) begin errors++; $display("FAIL stream_a cyc %0d: got dv=%b %b/%h expected %b %h", i, dv_a, ch_a, dout_a, m_dv_a, m_out_a); end
      checks++; if (level_a !== 3'(qa.size()) || ovf_a !== m_ovf_a) begin errors++; $display("FAIL stream_a_lvl cyc %0d: got %0d ovf=%b expected %0d ovf=%b", i, level_a, ovf_a, qa.size(), m_ovf_a); end
      checks++; if (dv_b !== m_dv_b || {ch_b, dout_b} !== m_out_b) begin errors++; $display("FAIL stream_b cyc %0d: got dv=%b %b/%h expected %b %h", i, dv_b, ch_b, dout_b, m_dv_b, m_out_b); end
      checks++; if (level_b !== 3'(qb.size()) || ovf_b !== m_ovf_b) begin errors++; $display("FAIL stream_b_lvl cyc %0d: got %0d ovf=%b expected %0d ovf=%b", i, level_b, ovf_b, qb.size(), m_ovf_b); end
    end
    rd_a = 1'b0; rd_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clocking();
    test_stereo();
    test_mode_filter();
    test_overflow();
    test_full_with_read();
    test_empty_disable();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_i2s_capture.md
Name: mic_i2s_capture

Overview:
- Parametrised next-generation microphone capture controller: merges clock generation, I2S deserialisation and sample buffering into one block.
- Generates the I2S bit clock (mclk) and word select (ws) for one or two MEMS microphones.
- Deserialises dataint into DAT_WIDTH-bit samples tagged with channel and buffers them in an internal FIFO.
- The read side serves the audio/PCM datapath; adds channel mode, overflow detection and fill level.

Parameters:
- DAT_WIDTH, 18, captured sample width (MSB-first); 1..SLOT_BITS-1.
- SLOT_BITS, 32, mclk periods per channel slot; frame = 2*SLOT_BITS.
- CLK_DIV, 32, clk cycles per mclk period; even, >=4.
- ADR_WIDTH, 9, FIFO address width; depth = 2**ADR_WIDTH.
- CH_MODE, 2, 0 = left only, 1 = right only, 2 = stereo.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  1 = run interface; 0 = idle
- mclk  out  1  I2S bit clock to microphone
- ws  out  1  word select; 0 = left slot, 1 = right slot
- lr  out  1  mic channel-select pin; 1 when CH_MODE==1, else 0
- dataint  in  1  serial data from microphone
- rd  in  1  FIFO read request
- data_out  out  DAT_WIDTH  sample read from FIFO
- ch_out  out  1  channel tag of data_out (0 = L, 1 = R)
- data_valid  out  1  1-cycle pulse: data_out/ch_out updated
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- level  out  ADR_WIDTH+1  FIFO occupancy, 0..2**ADR_WIDTH
- overflow  out  1  sticky: a sample was dropped
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset (reset==0 at a clk edge), all registered:
  - mclk=0, ws=0, data_out=0, ch_out=0, data_valid=0.
  - empty=1, full=0, level=0, overflow=0.
  - All counters and pointers = 0.
- Clock divider:
  - div_cnt counts 0..CLK_DIV/2-1 while enable=1.
  - At terminal count: mclk toggles and div_cnt returns to 0.
  - Rise event = terminal count with mclk==0. Fall event = terminal count with mclk==1.
  - First mclk rise occurs CLK_DIV/2 cycles after enable goes high.
- Framing:
  - bit_cnt (0..2*SLOT_BITS-1) increments on every fall event and wraps.
  - ws is registered, updates on fall events, and equals (next bit_cnt >= SLOT_BITS).
  - After reset: bit_cnt=0, ws=0, so the first slot is left.
- Capture:
  - On each rise event, slot index = bit_cnt mod SLOT_BITS.
  - Index 0 is the I2S one-bit delay and is ignored.
  - Indices 1..DAT_WIDTH: dataint is sampled at that clk edge and shifted in MSB-first.
  - Indices above DAT_WIDTH are discarded.
  - At index DAT_WIDTH, {ws, shift word} is pushed if allowed by CH_MODE:
    - CH_MODE 0: push only ws==0 words.
    - CH_MODE 1: push only ws==1 words.
    - CH_MODE 2: push all words.
- FIFO:
  - Depth 2**ADR_WIDTH; pointers wrap modulo depth; level = writes - reads.
  - Push with full=0: word is written; level increments unless a read occurs in the same cycle.
  - Push with full=1 and rd=0: word is dropped and overflow is set.
  - Push with full=1 and rd=1: read and write both succeed; level is unchanged; no overflow.
  - rd with empty=0: head word goes to data_out/ch_out at the next edge, with data_valid=1 for that one cycle (1-cycle latency).
  - rd with empty=1: ignored; no data_valid; outputs hold.
  - Simultaneous push and rd with empty=1: only the push takes effect; a later rd is required to read that word.
- Overflow flag:
  - clr_ovf=1 clears overflow.
  - If clr_ovf and a drop occur in the same cycle, overflow stays 1 (set wins).
- enable=0:
  - Within one cycle: mclk=0, ws=0, div_cnt=0, bit_cnt=0, shift register cleared, partial word discarded.
  - FIFO contents and the read side remain fully operational.
- Reset mid-frame: partial word lost; FIFO flushed; first post-reset frame starts at left slot, index 0.

Test Plan:
- Use DAT_WIDTH=6, SLOT_BITS=8, CLK_DIV=4, ADR_WIDTH=2 throughout.
- Clocking: reset low 3 cycles, then enable=1.
  - Required: mclk period 4 clk, first rise at cycle 2.
  - Required: ws toggles every 32 clk, on mclk falling edges.
- Stereo capture: drive L word 6'b101101 and R word 6'b010011 on slot indices 1..6, with other bits random.
  - Required: two rd pulses yield data_out=0x2D ch_out=0, then 0x13 ch_out=1, each with data_valid one cycle after rd.
- Mode filter: CH_MODE=1 over 4 frames.
  - Required: level=4, all ch_out=1, lr=1.
- Overflow: no reads for 5 stereo words.
  - Required: full=1, level=4, overflow=1.
  - Required: the 4 words read back are the first 4 in order.
  - Required: clr_ovf=1 clears overflow.
- Full with read: with full=1, assert rd in the push cycle.
  - Required: level stays 4, overflow stays 0.
- Empty read and disable mid-slot: rd while empty gives no data_valid.
  - Drop enable at slot index 3, then re-enable.
  - Required: mclk=0, ws=0 while disabled; no partial word pushed; first new word is a left sample.
